// File: rtl/fir_filter_param.sv
// Parametrised sequential multiply-accumulate FIR filter with alternating tap signs and a loadable coefficient bank.
// Optional macro FIR_SAT_EN: out-of-range results saturate instead of wrapping.
module fir_filter_param #(
  parameter int DATA_W    = 16,
  parameter int COEFF_W   = 16,
  parameter int NTAPS     = 4,
  parameter int CNT_LIMIT = 1000
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic [DATA_W-1:0]  sample_data,
  input  logic [COEFF_W-1:0] fir_coefficient,
  input  logic               data_ready,
  input  logic               load_coeff,
  output logic               modwait,
  output logic [DATA_W-1:0]  fir_out,
  output logic               err,
  output logic               one_k_samples
);

  localparam int PROD_W = DATA_W + COEFF_W;
  localparam int ACC_W  = PROD_W + $clog2(NTAPS) + 1;
  localparam int IDX_W  = $clog2(NTAPS);
  localparam int CNT_W  = $clog2(CNT_LIMIT + 1);
  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NTAPS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CNT_LIMIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOADC, S_SHIFT, S_MAC, S_OUT} state_t;

  state_t                     r_state, w_next_state;
  logic                       r_data_prev, r_load_prev;
  logic                       w_data_edge, w_load_edge;
  logic                       r_pending;
  logic [COEFF_W-1:0]         r_coeff  [NTAPS];
  logic [DATA_W-1:0]          r_sample [NTAPS];
  logic [IDX_W-1:0]           r_idx, r_k;
  logic [CNT_W-1:0]           r_cnt;
  logic signed [ACC_W-1:0]    r_acc;
  logic [PROD_W-1:0]          w_product;
  logic signed [ACC_W-1:0]    w_term, w_result;
  logic                       w_neg, w_over;
  logic [DATA_W-1:0]          w_fir_next;
  logic                       r_modwait, r_err, r_one_k;
  logic [DATA_W-1:0]          r_fir_out;

  assign w_data_edge = data_ready & ~r_data_prev;
  assign w_load_edge = load_coeff & ~r_load_prev;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_data_prev <= 1'b0;
      r_load_prev <= 1'b0;
      r_state     <= S_IDLE;
      r_modwait   <= 1'b0;
    end else begin
      r_data_prev <= data_ready;
      r_load_prev <= load_coeff;
      r_state     <= w_next_state;
      r_modwait   <= (w_next_state != S_IDLE);
    end
  end

  // NOTE: next-state is defaulted before the case so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_load_edge)                   w_next_state = S_LOADC;
        else if (w_data_edge || r_pending) w_next_state = S_SHIFT;
      end
      S_LOADC: w_next_state = S_IDLE;
      S_SHIFT: w_next_state = S_MAC;
      S_MAC:   if (r_k == LAST_TAP) w_next_state = S_OUT;
      S_OUT:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // At most one sample is queued; a load in IDLE defers a coincident data edge.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_pending <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_load_edge) r_pending <= r_pending | w_data_edge;
      else             r_pending <= 1'b0;
    end else if (w_data_edge) begin
      r_pending <= 1'b1;
    end
  end

  assign w_product = PROD_W'(r_sample[r_k]) * PROD_W'(r_coeff[r_k]);
  assign w_term    = {{(ACC_W - PROD_W){1'b0}}, w_product};

  // NOTE: the coefficient bank and delay line are reset because a fresh filter must read all-zero taps.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_coeff[i]  <= '0;
        r_sample[i] <= '0;
      end
      r_idx <= '0;
      r_k   <= '0;
      r_acc <= '0;
    end else begin
      unique case (r_state)
        S_LOADC: begin
          r_coeff[r_idx] <= fir_coefficient;
          r_idx          <= (r_idx == LAST_TAP) ? '0 : r_idx + IDX_W'(1);
        end
        S_SHIFT: begin
          r_sample[0] <= sample_data;
          for (int i = 1; i < NTAPS; i++) r_sample[i] <= r_sample[i-1];
          r_acc <= '0;
          r_k   <= '0;
        end
        S_MAC: begin
          r_acc <= r_k[0] ? (r_acc - w_term) : (r_acc + w_term);
          r_k   <= r_k + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Scale back from Q1.(COEFF_W-1) and classify the result range.
  assign w_result = r_acc >>> (COEFF_W - 1);
  assign w_neg    = w_result[ACC_W-1];
  assign w_over   = ~w_neg & (|w_result[ACC_W-2:DATA_W]);

`ifdef FIR_SAT_EN
  assign w_fir_next = w_neg ? '0 : (w_over ? '1 : w_result[DATA_W-1:0]);
`else
  assign w_fir_next = w_result[DATA_W-1:0];
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_fir_out <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_one_k   <= 1'b0;
    end else if (r_state == S_OUT) begin
      r_fir_out <= w_fir_next;
      r_err     <= w_neg | w_over;
      if (r_cnt == LAST_CNT) begin
        r_cnt   <= '0;
        r_one_k <= 1'b1;
      end else begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_one_k <= 1'b0;
      end
    end else begin
      r_one_k <= 1'b0;
    end
  end

  assign modwait       = r_modwait;
  assign fir_out       = r_fir_out;
  assign err           = r_err;
  assign one_k_samples = r_one_k;

endmodule

// File: tb/tb_fir_filter_param.sv
// Self-checking bench for fir_filter_param: default 4-tap instance plus an 8-tap, 12-bit instance.
// Expected values come from an arithmetic reference model of the filter held in the bench.
module tb_fir_filter_param;

  localparam int DATA_W    = 16;
  localparam int COEFF_W   = 16;
  localparam int NTAPS     = 4;
  localparam int CNT_LIMIT = 1000;
  localparam longint MAXV  = (longint'(1) << DATA_W) - 1;

  logic               clk = 1'b0;
  logic               n_reset = 1'b0;
  logic [DATA_W-1:0]  sample_data = '0;
  logic [COEFF_W-1:0] fir_coefficient = '0;
  logic               data_ready = 1'b0;
  logic               load_coeff = 1'b0;
  logic               modwait, err, one_k_samples;
  logic [DATA_W-1:0]  fir_out;

  logic [11:0] sd8 = '0;
  logic [15:0] fc8 = '0;
  logic        dr8 = 1'b0, lc8 = 1'b0;
  logic        mw8, er8, ok8;
  logic [11:0] fo8;

  int n_checks = 0;
  int n_errors = 0;

  longint mc[NTAPS];
  longint ms[NTAPS];
  int     mcnt, midx;

  always #5 clk = ~clk;

  fir_filter_param #(.DATA_W(DATA_W), .COEFF_W(COEFF_W), .NTAPS(NTAPS), .CNT_LIMIT(CNT_LIMIT)) u_dut (
    .clk(clk), .n_reset(n_reset), .sample_data(sample_data), .fir_coefficient(fir_coefficient),
    .data_ready(data_ready), .load_coeff(load_coeff), .modwait(modwait), .fir_out(fir_out),
    .err(err), .one_k_samples(one_k_samples));

  fir_filter_param #(.DATA_W(12), .COEFF_W(16), .NTAPS(8), .CNT_LIMIT(CNT_LIMIT)) u_dut8 (
    .clk(clk), .n_reset(n_reset), .sample_data(sd8), .fir_coefficient(fc8),
    .data_ready(dr8), .load_coeff(lc8), .modwait(mw8), .fir_out(fo8),
    .err(er8), .one_k_samples(ok8));

  task automatic model_reset();
    for (int i = 0; i < NTAPS; i++) begin
      mc[i] = 0;
      ms[i] = 0;
    end
    mcnt = 0;
    midx = 0;
  endtask

  task automatic model_load(input longint c);
    mc[midx] = c;
    midx = (midx + 1) % NTAPS;
  endtask

  // Filter output = floor(sum of alternating-sign products / 2^(COEFF_W-1)).
  task automatic model_sample(input longint d, output logic [DATA_W-1:0] f, output logic e,
                              output int pulse);
    longint acc, r;
    for (int k = NTAPS - 1; k > 0; k--) ms[k] = ms[k-1];
    ms[0] = d;
    acc = 0;
    for (int k = 0; k < NTAPS; k++) acc += ((k % 2 == 0) ? 1 : -1) * ms[k] * mc[k];
    r = acc >>> (COEFF_W - 1);
    e = (r < 0) || (r > MAXV);
`ifdef FIR_SAT_EN
    f = (r < 0) ? '0 : ((r > MAXV) ? DATA_W'(MAXV) : DATA_W'(r));
`else
    f = DATA_W'(r);
`endif
    mcnt++;
    pulse = (mcnt == CNT_LIMIT) ? 1 : 0;
    if (mcnt == CNT_LIMIT) mcnt = 0;
  endtask

  task automatic load_coef(input logic [COEFF_W-1:0] c);
    int busy;
    busy = 0;
    model_load(c);
    @(negedge clk);
    fir_coefficient = c;
    load_coeff = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (modwait) busy++;
    end
    load_coeff = 1'b0;
    n_checks++;
    if (busy !== 1) begin
      n_errors++;
      $display("FAIL load_modwait: got %0d cycles expected 1", busy);
    end
  endtask

  task automatic send_sample(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] exp_f;
    logic              exp_e;
    int                exp_p, busy, pulses;
    bit                done;
    model_sample(d, exp_f, exp_e, exp_p);
    busy = 0; pulses = 0; done = 1'b0;
    @(negedge clk);
    sample_data = d;
    data_ready = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (one_k_samples) pulses++;
      if (modwait) busy++;
      else if (busy > 0) done = 1'b1;
    end
    data_ready = 1'b0;
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL sample_timeout: modwait never completed for sample %0h", d);
    end
    n_checks++;
    if (busy !== NTAPS + 2) begin
      n_errors++;
      $display("FAIL sample_modwait: got %0d cycles expected %0d", busy, NTAPS + 2);
    end
    n_checks++;
    if (fir_out !== exp_f) begin
      n_errors++;
      $display("FAIL fir_out: sample %0h got %0h expected %0h", d, fir_out, exp_f);
    end
    n_checks++;
    if (err !== exp_e) begin
      n_errors++;
      $display("FAIL err: sample %0h got %0b expected %0b", d, err, exp_e);
    end
    n_checks++;
    if (pulses !== exp_p) begin
      n_errors++;
      $display("FAIL one_k_pulse: got %0d pulses expected %0d (count %0d)", pulses, exp_p, mcnt);
    end
  endtask

  task automatic test_reset();
    model_reset();
    n_reset = 1'b0;
    #3;
    n_checks++;
    if ({modwait, err, one_k_samples, fir_out} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got mw=%0b err=%0b ok=%0b out=%0h expected all 0",
               modwait, err, one_k_samples, fir_out);
    end
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic test_basic();
    load_coef(16'h4000); load_coef(16'h8000); load_coef(16'h8000); load_coef(16'h4000);
    repeat (4) send_sample(16'd100);
  endtask

  task automatic test_overflow();
    load_coef(16'hFFFF); load_coef(16'h0000); load_coef(16'h0000); load_coef(16'h0000);
    send_sample(16'hFFFF);
  endtask

  task automatic test_simultaneous();
    logic [DATA_W-1:0]  d, exp_f;
    logic [COEFF_W-1:0] c;
    logic               exp_e;
    int                 exp_p;
    logic [11:0]        pat, exp_pat;
    d = DATA_W'($urandom_range(0, 2000));
    c = COEFF_W'($urandom_range(0, 16'hFFFF));
    model_load(c);
    model_sample(d, exp_f, exp_e, exp_p);
    exp_pat = '0;
    exp_pat[0] = 1'b1;
    for (int i = 2; i <= NTAPS + 3; i++) exp_pat[i] = 1'b1;
    @(negedge clk);
    sample_data = d;
    fir_coefficient = c;
    data_ready = 1'b1;
    load_coeff = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pat[i] = modwait;
    end
    data_ready = 1'b0;
    load_coeff = 1'b0;
    n_checks++;
    if (pat !== exp_pat) begin
      n_errors++;
      $display("FAIL simul_modwait: got %b expected %b", pat, exp_pat);
    end
    n_checks++;
    if ({err, fir_out} !== {exp_e, exp_f}) begin
      n_errors++;
      $display("FAIL simul_result: got err=%0b out=%0h expected err=%0b out=%0h",
               err, fir_out, exp_e, exp_f);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < NTAPS; i++) load_coef(COEFF_W'($urandom_range(0, 16'hFFFF)));
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) send_sample(DATA_W'($urandom_range(0, 16'hFFFF)));
      else            send_sample(DATA_W'($urandom_range(0, 300)));
    end
  endtask

  // One queued sample while busy; extra data edges dropped and load edges ignored.
  task automatic test_back_to_back();
    logic [DATA_W-1:0] d1, d2, f1, f2;
    logic              e1, e2;
    int                p1, p2, busy;
    d1 = DATA_W'($urandom_range(0, 16'hFFFF));
    d2 = DATA_W'($urandom_range(0, 16'hFFFF));
    model_sample(d1, f1, e1, p1);
    model_sample(d2, f2, e2, p2);
    busy = 0;
    @(negedge clk);
    sample_data = d1;
    data_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (modwait) busy++;
      case (i)
        0: data_ready = 1'b0;
        1: begin
          sample_data = d2;
          data_ready = 1'b1;
          fir_coefficient = ~fir_coefficient;
          load_coeff = 1'b1;
        end
        2: begin
          data_ready = 1'b0;
          load_coeff = 1'b0;
        end
        3: data_ready = 1'b1;
        default: ;
      endcase
    end
    data_ready = 1'b0;
    n_checks++;
    if (busy !== 2 * (NTAPS + 2)) begin
      n_errors++;
      $display("FAIL b2b_modwait: got %0d cycles expected %0d", busy, 2 * (NTAPS + 2));
    end
    n_checks++;
    if ({err, fir_out} !== {e2, f2}) begin
      n_errors++;
      $display("FAIL b2b_result: got err=%0b out=%0h expected err=%0b out=%0h", err, fir_out, e2, f2);
    end
  endtask

  task automatic test_reset_mid_mac();
    @(negedge clk);
    sample_data = DATA_W'($urandom_range(1, 16'hFFFF));
    data_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    n_reset = 1'b0;
    #1;
    n_checks++;
    if ({modwait, err, one_k_samples, fir_out} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_mac: got mw=%0b err=%0b ok=%0b out=%0h expected all 0",
               modwait, err, one_k_samples, fir_out);
    end
    data_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    send_sample(DATA_W'($urandom_range(1, 16'hFFFF)));
  endtask

  task automatic test_one_k();
    for (int i = 0; i < NTAPS; i++) load_coef(COEFF_W'($urandom_range(0, 16'hFFFF)));
    for (int i = 0; i < CNT_LIMIT + 2; i++) send_sample(DATA_W'($urandom_range(0, 16'hFFFF)));
  endtask

  task automatic test_ntaps8();
    longint h8[8];
    longint acc, r;
    int     busy;
    bit     done;
    for (int i = 0; i < 8; i++) h8[i] = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      fc8 = 16'h8000;
      lc8 = 1'b1;
      repeat (2) @(negedge clk);
      lc8 = 1'b0;
    end
    for (int s = 0; s < 8; s++) begin
      for (int k = 7; k > 0; k--) h8[k] = h8[k-1];
      h8[0] = 10;
      acc = 0;
      for (int k = 0; k < 8; k++) acc += ((k % 2 == 0) ? 1 : -1) * h8[k] * 32768;
      r = acc >>> 15;
      busy = 0; done = 1'b0;
      @(negedge clk);
      sd8 = 12'd10;
      dr8 = 1'b1;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        if (mw8) busy++;
        else if (busy > 0) done = 1'b1;
      end
      dr8 = 1'b0;
      n_checks++;
      if (busy !== 10) begin
        n_errors++;
        $display("FAIL n8_modwait: sample %0d got %0d cycles expected 10", s, busy);
      end
      n_checks++;
      if ({er8, fo8} !== {1'b0, 12'(r)}) begin
        n_errors++;
        $display("FAIL n8_result: sample %0d got err=%0b out=%0d expected err=0 out=%0d",
                 s, er8, fo8, r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_simultaneous();
    test_random();
    test_back_to_back();
    test_reset_mid_mac();
    test_one_k();
    test_ntaps8();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
